// File: rtl/i2c_rx_timer.sv
// i2c_rx_timer: receive-side bit timer for an I2C slave.
// Synchronizes raw SCL/SDA, shifts eight bits MSB first on SCL rises, and
// sequences the ACK slot: byte_received -> ack_prep -> check_ack -> ack_done.
// Optional macro SCL_FILTER_EN: 3-flop synchronizers with a two-sample
// qualified edge detector, so single-cycle SCL glitches produce no edge.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no transfer; SCL edges ignored, waiting for start_found
// RX_BITS  | shifting data bits on SCL rises, falls ignored
// ACK_SLOT | byte complete, ack_prep high, waiting for the ACK-slot rise
// ACK_END  | ACK sampled, waiting for the SCL fall that ends the slot

module i2c_rx_timer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       scl,
  input  logic       sda_in,
  input  logic       start_found,
  input  logic       stop_found,
  output logic [7:0] rx_data,
  output logic       byte_received,
  output logic       ack_prep,
  output logic       check_ack,
  output logic       ack_bit,
  output logic       ack_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RX_BITS  = 2'd1,
    ACK_SLOT = 2'd2,
    ACK_END  = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] bit_cnt;
  logic       scl_rise;
  logic       scl_fall;
  logic       sda_bit;
  logic       sda_sync_unused;

`ifdef SCL_FILTER_EN
  // index 0 is the first flop (s1); reset to 1 so a released bus looks idle
  logic [2:0] scl_sync;
  logic [2:0] sda_sync;

  // three-deep synchronizers for SCL and SDA
  always_ff @(posedge clk) begin
    if (n_rst) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], scl};
      sda_sync <= {sda_sync[1:0], sda_in};
    end
  end

  // an edge needs the new level on two consecutive samples
  assign scl_rise        =  scl_sync[0] &  scl_sync[1] & ~scl_sync[2];
  assign scl_fall        = ~scl_sync[0] & ~scl_sync[1] &  scl_sync[2];
  assign sda_bit         = sda_sync[1];
  assign sda_sync_unused = sda_sync[2];
`else
  // index 0 is the first flop (s1); reset to 1 so a released bus looks idle
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;

  // two-deep synchronizers for SCL and SDA
  always_ff @(posedge clk) begin
    if (n_rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

  assign scl_rise        =  scl_sync[0] & ~scl_sync[1];
  assign scl_fall        = ~scl_sync[0] &  scl_sync[1];
  assign sda_bit         = sda_sync[0];
  // the second SDA flop exists only so both lines see identical delay
  assign sda_sync_unused = sda_sync[1];
`endif

  // receive FSM: stop beats start, and either beats a coincident SCL edge
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state         <= IDLE;
      bit_cnt       <= 4'd0;
      rx_data       <= 8'h00;
      byte_received <= 1'b0;
      ack_prep      <= 1'b0;
      check_ack     <= 1'b0;
      ack_bit       <= 1'b1;
      ack_done      <= 1'b0;
    end else begin
      byte_received <= 1'b0;
      check_ack     <= 1'b0;
      ack_done      <= 1'b0;
      if (stop_found) begin
        state    <= IDLE;
        bit_cnt  <= 4'd0;
        ack_prep <= 1'b0;
      end else if (start_found) begin
        state    <= RX_BITS;
        bit_cnt  <= 4'd0;
        ack_prep <= 1'b0;
      end else begin
        case (state)
          RX_BITS: begin
            if (scl_rise) begin
              rx_data <= {rx_data[6:0], sda_bit};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                byte_received <= 1'b1;
                ack_prep      <= 1'b1;
                state         <= ACK_SLOT;
              end
            end
          end
          ACK_SLOT: begin
            if (scl_rise) begin
              check_ack <= 1'b1;
              ack_bit   <= sda_bit;
              ack_prep  <= 1'b0;
              state     <= ACK_END;
            end
          end
          ACK_END: begin
            if (scl_fall) begin
              ack_done <= 1'b1;
              bit_cnt  <= 4'd0;
              state    <= RX_BITS;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_i2c_rx_timer.sv
// Self-checking bench for i2c_rx_timer: table of bytes with ACK values,
// plus directed sequences for stop, repeated start, reset and glitches.
module tb_i2c_rx_timer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       scl;
  logic       sda_in;
  logic       start_found;
  logic       stop_found;
  logic [7:0] rx_data;
  logic       byte_received;
  logic       ack_prep;
  logic       check_ack;
  logic       ack_bit;
  logic       ack_done;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int br_cnt = 0;
  int ca_cnt = 0;
  int ad_cnt = 0;
  int excl_viol = 0;

  i2c_rx_timer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .scl          (scl),
    .sda_in       (sda_in),
    .start_found  (start_found),
    .stop_found   (stop_found),
    .rx_data      (rx_data),
    .byte_received(byte_received),
    .ack_prep     (ack_prep),
    .check_ack    (check_ack),
    .ack_bit      (ack_bit),
    .ack_done     (ack_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // count clk cycles each pulse was high, and any overlap between pulses
  always @(posedge clk) begin
    if (byte_received === 1'b1) br_cnt++;
    if (check_ack === 1'b1) ca_cnt++;
    if (ack_done === 1'b1) ad_cnt++;
    if ($countones({byte_received === 1'b1, check_ack === 1'b1, ack_done === 1'b1}) > 1)
      excl_viol++;
  end

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic [7:0] exp_rx;
    logic       exp_ack;
  } vec_t;

  vec_t vecs[5];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sda_in = b;
    cyc(3);
    scl = 1'b1;
    cyc(4);
    scl = 1'b0;
    cyc(4);
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic pulse_start;
    start_found = 1'b1;
    cyc(1);
    start_found = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_stop;
    stop_found = 1'b1;
    cyc(1);
    stop_found = 1'b0;
    cyc(1);
  endtask

  initial begin
    int br0, ca0, ad0;
    logic [7:0] v;
    logic [7:0] exp_rx;

    vecs[0] = '{data: 8'hF0, ack: 1'b0, exp_rx: 8'hF0, exp_ack: 1'b0};
    vecs[1] = '{data: 8'hA5, ack: 1'b1, exp_rx: 8'hA5, exp_ack: 1'b1};
    vecs[2] = '{data: 8'h00, ack: 1'b0, exp_rx: 8'h00, exp_ack: 1'b0};
    vecs[3] = '{data: 8'hFF, ack: 1'b1, exp_rx: 8'hFF, exp_ack: 1'b1};
    vecs[4] = '{data: 8'h81, ack: 1'b0, exp_rx: 8'h81, exp_ack: 1'b0};

    n_rst = 1'b1; scl = 1'b1; sda_in = 1'b1; start_found = 1'b0; stop_found = 1'b0;
    cyc(3);
    check("reset rx_data", 32'(rx_data), 32'h00);
    check("reset ack_bit", 32'(ack_bit), 32'h1);
    check("reset ack_prep", 32'(ack_prep), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset pulses", 32'({byte_received, check_ack, ack_done}), 32'h0);
    n_rst = 1'b0;
    cyc(2);
    check("idle busy", 32'(busy), 32'h0);

    // main transfer: one start, then bytes back to back
    pulse_start;
    check("start busy", 32'(busy), 32'h1);
    scl = 1'b0;
    cyc(4);
    for (int k = 0; k < 5; k++) begin
      br0 = br_cnt; ca0 = ca_cnt; ad0 = ad_cnt;
      send_byte(vecs[k].data);
      check($sformatf("v%0d rx_data", k), 32'(rx_data), 32'(vecs[k].exp_rx));
      check($sformatf("v%0d byte_received", k), 32'(br_cnt - br0), 32'd1);
      check($sformatf("v%0d ack_prep set", k), 32'(ack_prep), 32'h1);
      check($sformatf("v%0d no early ack", k), 32'(ca_cnt - ca0), 32'd0);
      send_bit(vecs[k].ack);
      check($sformatf("v%0d check_ack", k), 32'(ca_cnt - ca0), 32'd1);
      check($sformatf("v%0d ack_bit", k), 32'(ack_bit), 32'(vecs[k].exp_ack));
      check($sformatf("v%0d ack_prep clr", k), 32'(ack_prep), 32'h0);
      check($sformatf("v%0d ack_done", k), 32'(ad_cnt - ad0), 32'd1);
      check($sformatf("v%0d busy", k), 32'(busy), 32'h1);
      check($sformatf("v%0d rx hold", k), 32'(rx_data), 32'(vecs[k].exp_rx));
    end

    // stop after five bits of 8'h3C: partial bits shifted, no byte
    pulse_start;
    br0 = br_cnt;
    v = 8'h3C;
    for (int i = 7; i >= 3; i--) send_bit(v[i]);
    exp_rx = {8'h81 << 5} | 8'b0000_0111;
    pulse_stop;
    check("stop busy", 32'(busy), 32'h0);
    check("stop no byte", 32'(br_cnt - br0), 32'd0);
    check("stop rx_data", 32'(rx_data), 32'(exp_rx));
    check("stop ack_prep", 32'(ack_prep), 32'h0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("idle rx hold", 32'(rx_data), 32'(exp_rx));
    check("idle no byte", 32'(br_cnt - br0), 32'd0);

    // repeated start after three bits, then 8'h79
    pulse_start;
    br0 = br_cnt;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    pulse_start;
    check("rs busy", 32'(busy), 32'h1);
    send_byte(8'h79);
    check("rs rx_data", 32'(rx_data), 32'h79);
    check("rs one byte", 32'(br_cnt - br0), 32'd1);
    send_bit(1'b0);
    check("rs ack_bit", 32'(ack_bit), 32'h0);
    start_found = 1'b1;
    stop_found = 1'b1;
    cyc(1);
    start_found = 1'b0;
    stop_found = 1'b0;
    cyc(1);
    check("start+stop idle", 32'(busy), 32'h0);

    // reset in the middle of a byte
    pulse_start;
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    sda_in = 1'b1;
    n_rst = 1'b1;
    cyc(1);
    check("midrst rx_data", 32'(rx_data), 32'h00);
    check("midrst ack_bit", 32'(ack_bit), 32'h1);
    check("midrst busy", 32'(busy), 32'h0);
    check("midrst ack_prep", 32'(ack_prep), 32'h0);
    check("midrst pulses", 32'({byte_received, check_ack, ack_done}), 32'h0);
    n_rst = 1'b0;
    cyc(3);
    br0 = br_cnt;
    send_byte(8'hFF);
    check("no start rx_data", 32'(rx_data), 32'h00);
    check("no start busy", 32'(busy), 32'h0);
    check("no start byte", 32'(br_cnt - br0), 32'd0);

    // one-cycle SCL high pulse with SDA = 1
    pulse_start;
    sda_in = 1'b1;
    cyc(3);
    scl = 1'b1;
    cyc(1);
    scl = 1'b0;
    cyc(6);
`ifdef SCL_FILTER_EN
    check("glitch no shift", 32'(rx_data), 32'h00);
`else
    check("short pulse shift", 32'(rx_data), 32'h01);
`endif
    pulse_stop;

    check("pulse exclusivity", 32'(excl_viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_rx_timer.md
I2C_RX_TIMER -- requirements
Module: i2c_rx_timer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: sole system clock; every flop updates on its rising edge.
REQ-002 The block SHALL have port n_rst, input, 1 bit: synchronous, active-high reset (1 = reset, sampled on the clk rising edge).
REQ-003 The block SHALL have port scl, input, 1 bit: raw, unsynchronized I2C clock.
REQ-004 The block SHALL have port sda_in, input, 1 bit: raw, unsynchronized I2C data.
REQ-005 The block SHALL have port start_found, input, 1 bit: one-cycle start-condition pulse from the decode stage.
REQ-006 The block SHALL have port stop_found, input, 1 bit: one-cycle stop-condition pulse from the decode stage.
REQ-007 The block SHALL have port rx_data, output, 8 bits: assembled byte, MSB first; drives starting_byte of the decode stage.
REQ-008 The block SHALL have port byte_received, output, 1 bit: one-cycle pulse when the 8th bit has been shifted in.
REQ-009 The block SHALL have port ack_prep, output, 1 bit: level, high from byte_received until the ACK-slot SCL rise.
REQ-010 The block SHALL have port check_ack, output, 1 bit: one-cycle pulse on the 9th (ACK-slot) SCL rise.
REQ-011 The block SHALL have port ack_bit, output, 1 bit: SDA value sampled with check_ack (0 = ACK, 1 = NACK).
REQ-012 The block SHALL have port ack_done, output, 1 bit: one-cycle pulse on the SCL fall that ends the ACK slot.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 scl and sda_in SHALL each pass through identical 2-flop synchronizers (s1, s2); rise = s1 & !s2, fall = !s1 & s2; shifted SDA = sda s1.
REQ-015 rx_data SHALL update on the 2nd clk edge after the first edge at which scl is sampled high.
REQ-016 FSM states SHALL be IDLE, RX_BITS, ACK_SLOT and ACK_END; after reset the state is IDLE.
REQ-017 IDLE: start_found SHALL move to RX_BITS with bit counter = 0; SCL edges SHALL be ignored.
REQ-018 RX_BITS: each rise SHALL set rx_data <= {rx_data[6:0], sda}, increment the 4-bit counter, and ignore falls.
REQ-019 When the counter reaches 8, the block SHALL pulse byte_received on the same edge, set ack_prep, and enter ACK_SLOT.
REQ-020 ACK_SLOT: the next rise SHALL pulse check_ack, capture ack_bit, clear ack_prep, and enter ACK_END.
REQ-021 ACK_END: the next fall SHALL pulse ack_done, clear the counter, and return to RX_BITS; rx_data SHALL hold until the next rise.
REQ-022 stop_found in any state SHALL force IDLE, clear the counter, clear ack_prep, and leave rx_data and ack_bit unchanged.
REQ-023 start_found in any non-IDLE state (repeated start) SHALL force RX_BITS, clear the counter, and clear ack_prep.
REQ-024 If start_found and stop_found are asserted in the same cycle, stop_found SHALL win.
REQ-025 If a start/stop pulse and an SCL edge occur in the same cycle, the start/stop pulse SHALL win and the edge SHALL be discarded.
REQ-026 byte_received, check_ack and ack_done SHALL each be exactly one clk wide and mutually exclusive.

Reset
REQ-027 With n_rst = 1 at a clk edge, the block SHALL set rx_data = 8'h00, all pulses = 0, ack_prep = 0, ack_bit = 1, busy = 0, counter = 0, state = IDLE and synchronizers = 1 (bus idle).
REQ-028 Reset asserted mid-byte SHALL abandon the partial byte; after release the block SHALL require a new start_found.

Configuration
REQ-029 When SCL_FILTER_EN is defined, both synchronizers SHALL be 3 flops deep and rise SHALL be s1 & s2 & !s3, fall SHALL be !s1 & !s2 & s3, and the shifted SDA SHALL be taken from s2.
REQ-030 With SCL_FILTER_EN defined, REQ-015 latency SHALL be 3 edges and single-cycle SCL glitches SHALL produce no edge.
REQ-031 Without SCL_FILTER_EN, REQ-014 and REQ-015 SHALL apply unchanged.

Verification
REQ-032 Reset, start_found, then bits 1111_0000 -> rx_data = 8'hF0, exactly one byte_received pulse, ack_prep = 1.
REQ-033 Continue with SDA = 0 in the ACK slot -> check_ack pulse, ack_bit = 0, ack_prep = 0; the SCL fall gives an ack_done pulse and busy stays 1.
REQ-034 Second byte 8'hA5, then SDA = 1 in the ACK slot -> rx_data = 8'hA5, ack_bit = 1.
REQ-035 stop_found after 5 bits of 8'h3C -> IDLE, busy = 0, no byte_received; further SCL toggles do not change rx_data.
REQ-036 Repeated start after 3 bits, then 8'h79 -> rx_data = 8'h79 with exactly one byte_received; also start and stop in the same cycle -> IDLE.
REQ-037 Reset pulsed mid-byte -> all outputs at REQ-027 values next cycle; with SCL_FILTER_EN, a one-cycle SCL glitch -> no shift.
